// File: rtl/seg_scan_if.sv
// Valid/ready word transfer into the seven-segment scan controller.
interface seg_scan_if;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/seg_scan_ctrl.sv
// Four-digit common-anode seven-segment scanner with frame-aligned
// double-buffered updates, per-slot anode-off guard and leading-zero blanking.
module seg_scan_ctrl #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned GUARD    = 500
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic         blank_lz_i,
  seg_scan_if.slave    bus,
  output logic [6:0]   seg_n_o,
  output logic [3:0]   an_n_o,
  output logic         frame_tick_o
);

  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] SLOT_PRE  = SW'(SCAN_DIV - 2);
  localparam logic [SW-1:0] GUARD_CNT = SW'(GUARD);

  typedef enum logic [1:0] {OFF, GUARD_ST, DRIVE} state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [1:0]    digit_q, digit_d;
  logic [15:0]   disp_q, disp_d;
  logic [15:0]   pend_q, pend_d;
  logic          pend_v_q, pend_v_d;
  logic [6:0]    seg_d;
  logic [3:0]    an_d;
  logic          tick_d;

  logic          running;
  logic          boundary;
  logic          xfer;
  logic          lit;
  logic          blank;
  logic [3:0]    nib;
  logic [6:0]    glyph;

  assign bus.in_ready = !pend_v_q;
  assign xfer         = bus.in_valid && !pend_v_q;
  assign running      = (state_q != OFF);
  assign boundary     = running && en_i && (digit_q == 2'd3) && (slot_q == SLOT_LAST);

  always_comb begin
    state_d = OFF;
    slot_d  = '0;
    digit_d = '0;
    if (en_i) begin
      if (!running) begin
        slot_d  = '0;
        digit_d = '0;
      end else if (slot_q == SLOT_LAST) begin
        slot_d  = '0;
        digit_d = digit_q + 2'd1;
      end else begin
        slot_d  = slot_q + 1'b1;
        digit_d = digit_q;
      end
      state_d = (slot_d < GUARD_CNT) ? GUARD_ST : DRIVE;
    end
  end

  // A pending word drains at a frame boundary or whenever the scan is off;
  // a boundary transfer with nothing pending bypasses the buffer.
  always_comb begin
    disp_d   = disp_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    if (pend_v_q && (boundary || !running)) begin
      disp_d   = pend_q;
      pend_v_d = 1'b0;
    end else if (xfer && boundary) begin
      disp_d = bus.in_data;
    end else if (xfer) begin
      pend_d   = bus.in_data;
      pend_v_d = 1'b1;
    end
  end

  always_comb begin
    nib = disp_q[{digit_q, 2'b00} +: 4];
    case (digit_q)
      2'd3:    blank = blank_lz_i && (disp_q[15:12] == 4'h0);
      2'd2:    blank = blank_lz_i && (disp_q[15:8]  == 8'h00);
      2'd1:    blank = blank_lz_i && (disp_q[15:4]  == 12'h000);
      default: blank = 1'b0;
    endcase
    case (nib)
      4'h0:    glyph = 7'h40;
      4'h1:    glyph = 7'h79;
      4'h2:    glyph = 7'h24;
      4'h3:    glyph = 7'h30;
      4'h4:    glyph = 7'h19;
      4'h5:    glyph = 7'h12;
      4'h6:    glyph = 7'h02;
      4'h7:    glyph = 7'h78;
      4'h8:    glyph = 7'h00;
      4'h9:    glyph = 7'h10;
      4'hA:    glyph = 7'h08;
      4'hB:    glyph = 7'h03;
      4'hC:    glyph = 7'h46;
      4'hD:    glyph = 7'h21;
      4'hE:    glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase
    // en_i gates the anodes directly so the display goes dark one cycle after en drops.
    lit    = en_i && (state_q == DRIVE);
    an_d   = lit ? ~(4'b0001 << digit_q) : '1;
    seg_d  = (lit && !blank) ? glyph : '1;
    // Registered one cycle ahead so the pulse coincides with the boundary cycle.
    tick_d = running && en_i && (digit_q == 2'd3) && (slot_q == SLOT_PRE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= OFF;
      slot_q       <= '0;
      digit_q      <= '0;
      disp_q       <= '0;
      pend_q       <= '0;
      pend_v_q     <= 1'b0;
      seg_n_o      <= '1;
      an_n_o       <= '1;
      frame_tick_o <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      digit_q      <= digit_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pend_v_q     <= pend_v_d;
      seg_n_o      <= seg_d;
      an_n_o       <= an_d;
      frame_tick_o <= tick_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl with SCAN_DIV=8, GUARD=2 (32-cycle frame).
module tb_seg_scan_ctrl;

  localparam int SD = 8;
  localparam int G  = 2;
  localparam logic [6:0] SEG_TBL [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        blank_lz;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic        frame_tick;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_tick = -1;
  logic [15:0] exp_q [$];

  seg_scan_if dif ();

  seg_scan_ctrl #(.SCAN_DIV(SD), .GUARD(G)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_i         (en),
    .blank_lz_i   (blank_lz),
    .bus          (dif.slave),
    .seg_n_o      (seg_n),
    .an_n_o       (an_n),
    .frame_tick_o (frame_tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (frame_tick === 1'b1) last_tick = cyc;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] exp_seg(input logic [15:0] w, input int k, input logic bl);
    logic [15:0] up;
    up = w >> (4 * k);
    if (bl && k != 0 && up == 16'h0) return 7'h7F;
    return SEG_TBL[up[3:0]];
  endfunction

  // Drive a word (caller at a negedge) and hold it until accepted.
  task automatic send(input logic [15:0] w, output int acc);
    acc = -1;
    dif.in_data  = w;
    dif.in_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      if (dif.in_ready === 1'b1) begin
        acc = cyc;
        exp_q.push_back(w);
        break;
      end
      @(negedge clk);
    end
    if (acc < 0) begin
      checks++; errors++;
      $display("FAIL send_timeout word=%h never accepted", w);
    end
    @(posedge clk);
    #1 dif.in_valid = 1'b0;
  endtask

  // Captures one full output frame following a frame_tick (offsets 2..33).
  task automatic grab_frame(input bit at_tick, output logic [15:0] an_p, output logic [27:0] seg_p,
                            output int glitch, output int ticks, output int toff, output logic rdy1);
    int n, k, p;
    glitch = 0; ticks = 0; toff = -1; an_p = '1; seg_p = '1; rdy1 = 1'bx;
    if (!at_tick) begin
      n = 0;
      do begin @(negedge clk); n++; end while (frame_tick !== 1'b1 && n < 100);
      if (frame_tick !== 1'b1) begin
        checks++; errors++;
        $display("FAIL frame_tick_timeout no tick within 100 cycles");
        return;
      end
    end
    for (int o = 1; o <= 33; o++) begin
      @(negedge clk);
      if (o == 1) rdy1 = dif.in_ready;
      if (o >= 2) begin
        if (frame_tick === 1'b1) begin ticks++; toff = o; end
        k = (o - 2) / SD;
        p = (o - 2) % SD;
        if (p < G) begin
          if (an_n !== 4'hF || seg_n !== 7'h7F) glitch++;
        end else if (p == G) begin
          an_p[4*k +: 4]  = an_n;
          seg_p[7*k +: 7] = seg_n;
        end else if (an_n !== an_p[4*k +: 4] || seg_n !== seg_p[7*k +: 7]) begin
          glitch++;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      en = 1'($urandom); blank_lz = 1'($urandom);
      dif.in_data = 16'($urandom); dif.in_valid = 1'($urandom);
      #1;
      checks++;
      if (seg_n !== 7'h7F || an_n !== 4'hF || dif.in_ready !== 1'b1 || frame_tick !== 1'b0) begin
        errors++;
        $display("FAIL reset_state seg=%h an=%h rdy=%b tick=%b, required 7f f 1 0", seg_n, an_n, dif.in_ready, frame_tick);
      end
    end
    @(negedge clk);
    en = 1'b1; blank_lz = 1'b0; dif.in_valid = 1'b0; rst_n = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      logic [3:0] ea;
      logic [6:0] es;
      @(negedge clk);
      ea = (n >= 4 && n <= 9) ? 4'hE : 4'hF;
      es = (n >= 4 && n <= 9) ? 7'h40 : 7'h7F;
      checks++;
      if (an_n !== ea || seg_n !== es) begin
        errors++;
        $display("FAIL reset_startup cycle %0d an=%h seg=%h, required %h %h", n, an_n, seg_n, ea, es);
      end
    end
  endtask

  task automatic test_update();
    int acc, glitch, ticks, toff;
    logic [15:0] an_p, w;
    logic [27:0] seg_p;
    logic rdy1;
    send(16'h1234, acc);
    checks++;
    if (dif.in_ready !== 1'b0) begin
      errors++; $display("FAIL update_ready_low rdy=%b, required 0", dif.in_ready);
    end
    grab_frame(1'b0, an_p, seg_p, glitch, ticks, toff, rdy1);
    checks++;
    if (rdy1 !== 1'b1) begin errors++; $display("FAIL update_ready_after_boundary rdy=%b, required 1", rdy1); end
    checks++;
    if (glitch !== 0 || ticks !== 1 || toff !== 32) begin
      errors++; $display("FAIL update_timing glitch=%0d ticks=%0d off=%0d, required 0 1 32", glitch, ticks, toff);
    end
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL update_scoreboard empty, required 1 entry"); w = '0; end
    else w = exp_q.pop_front();
    for (int k = 0; k < 4; k++) begin
      logic [3:0] ea;
      ea = ~(4'b0001 << k);
      checks++;
      if (an_p[4*k +: 4] !== ea || seg_p[7*k +: 7] !== exp_seg(w, k, blank_lz)) begin
        errors++; $display("FAIL update_digit%0d an=%h seg=%h, required %h %h", k, an_p[4*k +: 4], seg_p[7*k +: 7], ea, exp_seg(w, k, blank_lz));
      end
    end
  endtask

  task automatic test_boundary_empty();
    int n, glitch, ticks, toff;
    logic [15:0] an_p, w;
    logic [27:0] seg_p;
    logic rdy1;
    n = 0;
    do begin @(negedge clk); n++; end while (frame_tick !== 1'b1 && n < 100);
    checks++;
    if (frame_tick !== 1'b1 || dif.in_ready !== 1'b1) begin
      errors++; $display("FAIL boundary_sync tick=%b rdy=%b, required 1 1", frame_tick, dif.in_ready);
    end
    dif.in_data = 16'hABCD; dif.in_valid = 1'b1;
    exp_q.push_back(16'hABCD);
    @(posedge clk);
    #1 dif.in_valid = 1'b0;
    grab_frame(1'b1, an_p, seg_p, glitch, ticks, toff, rdy1);
    checks++;
    if (rdy1 !== 1'b1) begin errors++; $display("FAIL boundary_ready rdy=%b, required 1", rdy1); end
    checks++;
    if (glitch !== 0 || ticks !== 1 || toff !== 32) begin
      errors++; $display("FAIL boundary_timing glitch=%0d ticks=%0d off=%0d, required 0 1 32", glitch, ticks, toff);
    end
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL boundary_scoreboard empty, required 1 entry"); w = '0; end
    else w = exp_q.pop_front();
    for (int k = 0; k < 4; k++) begin
      logic [3:0] ea;
      ea = ~(4'b0001 << k);
      checks++;
      if (an_p[4*k +: 4] !== ea || seg_p[7*k +: 7] !== exp_seg(w, k, blank_lz)) begin
        errors++; $display("FAIL boundary_digit%0d an=%h seg=%h, required %h %h", k, an_p[4*k +: 4], seg_p[7*k +: 7], ea, exp_seg(w, k, blank_lz));
      end
    end
  endtask

  task automatic test_back_to_back();
    int a1, a2, t_at, glitch, ticks, toff;
    logic [15:0] an_p, w;
    logic [27:0] seg_p;
    logic rdy1;
    for (int f = 0; f < 2; f++) begin
      if (f == 0) begin
        fork
          begin
            send(16'h1111, a1);
            send(16'h2222, a2);
            t_at = last_tick;
          end
          grab_frame(1'b0, an_p, seg_p, glitch, ticks, toff, rdy1);
        join
        checks++;
        if (a2 !== t_at + 1) begin
          errors++; $display("FAIL b2b_accept_cycle accepted=%0d, required %0d", a2, t_at + 1);
        end
      end else begin
        grab_frame(1'b0, an_p, seg_p, glitch, ticks, toff, rdy1);
      end
      checks++;
      if (glitch !== 0 || ticks !== 1 || toff !== 32) begin
        errors++; $display("FAIL b2b_timing frame%0d glitch=%0d ticks=%0d off=%0d, required 0 1 32", f, glitch, ticks, toff);
      end
      checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_scoreboard empty, required entry"); w = '0; end
      else w = exp_q.pop_front();
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (seg_p[7*k +: 7] !== exp_seg(w, k, blank_lz) || an_p[4*k +: 4] !== ~(4'b0001 << k)) begin
          errors++; $display("FAIL b2b_digit f%0d d%0d an=%h seg=%h, required seg %h", f, k, an_p[4*k +: 4], seg_p[7*k +: 7], exp_seg(w, k, blank_lz));
        end
      end
    end
  endtask

  task automatic test_blanking();
    logic [15:0] words [2];
    int acc, glitch, ticks, toff;
    logic [15:0] an_p, w;
    logic [27:0] seg_p;
    logic rdy1;
    words[0] = 16'h0050;
    words[1] = 16'h0000;
    blank_lz = 1'b1;
    for (int f = 0; f < 2; f++) begin
      send(words[f], acc);
      grab_frame(1'b0, an_p, seg_p, glitch, ticks, toff, rdy1);
      checks++;
      if (glitch !== 0) begin errors++; $display("FAIL blank_timing word%0d glitch=%0d, required 0", f, glitch); end
      checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL blank_scoreboard empty, required entry"); w = '0; end
      else w = exp_q.pop_front();
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (seg_p[7*k +: 7] !== exp_seg(w, k, 1'b1) || an_p[4*k +: 4] !== ~(4'b0001 << k)) begin
          errors++; $display("FAIL blank_digit w=%h d%0d an=%h seg=%h, required seg %h", w, k, an_p[4*k +: 4], seg_p[7*k +: 7], exp_seg(w, k, 1'b1));
        end
      end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_enable_reset();
    int n, acc, glitch, ticks, toff;
    logic [15:0] an_p, w;
    logic [27:0] seg_p;
    logic rdy1;
    n = 0;
    do begin @(negedge clk); n++; end while (frame_tick !== 1'b1 && n < 100);
    @(negedge clk);
    send(16'h5A5A, acc);
    repeat (21) @(negedge clk);
    checks++;
    if (an_n !== 4'hB || dif.in_ready !== 1'b0) begin
      errors++; $display("FAIL en_digit2 an=%h rdy=%b, required b 0", an_n, dif.in_ready);
    end
    en = 1'b0;
    @(negedge clk);
    checks++;
    if (an_n !== 4'hF || seg_n !== 7'h7F) begin
      errors++; $display("FAIL en_off an=%h seg=%h, required f 7f", an_n, seg_n);
    end
    @(negedge clk);
    checks++;
    if (dif.in_ready !== 1'b1) begin errors++; $display("FAIL en_off_drain rdy=%b, required 1", dif.in_ready); end
    en = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL en_scoreboard empty, required entry"); w = '0; end
    else w = exp_q.pop_front();
    checks++;
    if (an_n !== 4'hE || seg_n !== exp_seg(w, 0, 1'b0)) begin
      errors++; $display("FAIL en_restart an=%h seg=%h, required e %h", an_n, seg_n, exp_seg(w, 0, 1'b0));
    end
    send(16'h9999, acc);
    checks++;
    if (dif.in_ready !== 1'b0) begin errors++; $display("FAIL rst_pend rdy=%b, required 0", dif.in_ready); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (dif.in_ready !== 1'b1 || an_n !== 4'hF || seg_n !== 7'h7F || frame_tick !== 1'b0) begin
      errors++; $display("FAIL rst_async rdy=%b an=%h seg=%h tick=%b, required 1 f 7f 0", dif.in_ready, an_n, seg_n, frame_tick);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    exp_q.push_back(16'h0000);
    grab_frame(1'b0, an_p, seg_p, glitch, ticks, toff, rdy1);
    w = exp_q.pop_front();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (seg_p[7*k +: 7] !== exp_seg(w, k, 1'b0) || an_p[4*k +: 4] !== ~(4'b0001 << k)) begin
        errors++; $display("FAIL rst_discard d%0d an=%h seg=%h, required seg %h", k, an_p[4*k +: 4], seg_p[7*k +: 7], exp_seg(w, k, 1'b0));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; blank_lz = 1'b0;
    dif.in_data = '0; dif.in_valid = 1'b0;
    test_reset();
    test_update();
    test_boundary_empty();
    test_back_to_back();
    test_blanking();
    test_enable_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_leftover entries=%0d, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
